// File: rtl/cam_fill_ctrl_pkg.sv
// Shared types and reset/idle constants for the CAM fill controller.
// The state encoding is shared by the controller and any bench-side decoding.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP,
        FLUSH
    } state_t;

    localparam state_t RST_STATE        = IDLE;
    localparam logic   RST_REQ_READY    = 1'b1;
    localparam logic   IDLE_CAM_WRITE_N = 1'b1;

endpackage

// File: rtl/cam_fill_ctrl_if.sv
// Bundle of client, CAM and backing-memory signals around the fill controller.
// master = controller side, slave = client/CAM/memory side.
interface cam_fill_ctrl_if #(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int TAG_SZ    = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
);
    import cam_ctrl_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [TAG_SZ-1:0]   req_tag;
    logic                rsp_valid;
    logic [BITS-1:0]     rsp_data;
    logic                rsp_hit;
    logic                flush;
    logic                cam_read;
    logic [TAG_SZ-1:0]   cam_check_tag;
    logic [BITS-1:0]     cam_data;
    logic                cam_found;
    logic                cam_write_;
    logic [ADDR_LEFT:0]  cam_w_addr;
    logic [BITS-1:0]     cam_wdata;
    logic [TAG_SZ-1:0]   cam_new_tag;
    logic                cam_new_valid;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [TAG_SZ-1:0]   mem_req_tag;
    logic                mem_rsp_valid;
    logic [BITS-1:0]     mem_rsp_data;

    modport master (
        input  req_valid, req_tag, flush, cam_data, cam_found,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_hit, cam_read, cam_check_tag,
               cam_write_, cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid,
               mem_req_valid, mem_req_tag
    );

    modport slave (
        output req_valid, req_tag, flush, cam_data, cam_found,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, cam_read, cam_check_tag,
               cam_write_, cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid,
               mem_req_valid, mem_req_tag
    );

endinterface

// File: rtl/cam_fill_ctrl_victim_ptr.sv
// Round-robin replacement pointer: advances once per fill, cleared by flush.
module cam_victim_ptr
    import cam_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               inc,
    input  logic               clr,
    output logic [ADDR_LEFT:0] ptr
);

    logic [ADDR_LEFT:0] ptr_q;
    logic [ADDR_LEFT:0] ptr_d;

    // Clear has priority so a flush always leaves the pointer at entry 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            if (ptr_q == (ADDR_LEFT+1)'(WORDS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + (ADDR_LEFT+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/cam_fill_ctrl.sv
// Request-side CAM controller: lookup, miss fetch from memory, fill and flush.
// All outputs are registered and derived from the next state.
module cam_fill_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int TAG_SZ    = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic            clk,
    input  logic            rst_,
    cam_fill_ctrl_if.master bus
);

    state_t              state_q, state_d;
    logic [TAG_SZ-1:0]   tag_q, tag_d;
    logic [BITS-1:0]     data_q, data_d;
    logic                hit_q, hit_d;

    logic                req_ready_q, req_ready_d;
    logic                cam_read_q, cam_read_d;
    logic [TAG_SZ-1:0]   cam_check_tag_q, cam_check_tag_d;
    logic                cam_write_n_q, cam_write_n_d;
    logic [ADDR_LEFT:0]  cam_w_addr_q, cam_w_addr_d;
    logic [BITS-1:0]     cam_wdata_q, cam_wdata_d;
    logic [TAG_SZ-1:0]   cam_new_tag_q, cam_new_tag_d;
    logic                cam_new_valid_q, cam_new_valid_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [TAG_SZ-1:0]   mem_req_tag_q, mem_req_tag_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [BITS-1:0]     rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;

    logic [ADDR_LEFT:0]  victim;
    logic                victim_inc;
    logic                victim_clr;

    assign victim_inc = (state_q == FILL);
    assign victim_clr = (state_q == FLUSH);

    cam_victim_ptr #(
        .WORDS     (WORDS),
        .ADDR_LEFT (ADDR_LEFT)
    ) u_victim_ptr (
        .clk (clk),
        .rst_(rst_),
        .inc (victim_inc),
        .clr (victim_clr),
        .ptr (victim)
    );

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        hit_d   = hit_q;

        case (state_q)
            IDLE: begin
                // Flush wins over a request arriving in the same cycle.
                if (bus.flush) begin
                    state_d = FLUSH;
                end else if (bus.req_valid) begin
                    tag_d   = bus.req_tag;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cam_found) begin
                    data_d  = bus.cam_data;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    hit_d   = 1'b0;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    data_d  = bus.mem_rsp_data;
                    state_d = FILL;
                end
            end
            FILL:    state_d = RESP;
            RESP:    state_d = IDLE;
            FLUSH: begin
                // The write address doubles as the flush sweep counter.
                if (cam_w_addr_q == (ADDR_LEFT+1)'(WORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d     = 1'b0;
        cam_read_d      = 1'b0;
        cam_check_tag_d = '0;
        cam_write_n_d   = IDLE_CAM_WRITE_N;
        cam_w_addr_d    = '0;
        cam_wdata_d     = '0;
        cam_new_tag_d   = '0;
        cam_new_valid_d = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_req_tag_d   = '0;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = '0;
        rsp_hit_d       = 1'b0;

        case (state_d)
            IDLE:    req_ready_d = 1'b1;
            LOOKUP: begin
                cam_read_d      = 1'b1;
                cam_check_tag_d = tag_d;
            end
            MEM_REQ: begin
                mem_req_valid_d = 1'b1;
                mem_req_tag_d   = tag_d;
            end
            FILL: begin
                cam_write_n_d   = 1'b0;
                cam_w_addr_d    = victim;
                cam_wdata_d     = data_d;
                cam_new_tag_d   = tag_d;
                cam_new_valid_d = 1'b1;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_d;
                rsp_hit_d   = hit_d;
            end
            FLUSH: begin
                cam_write_n_d = 1'b0;
                cam_w_addr_d  = (state_q == FLUSH) ? cam_w_addr_q + (ADDR_LEFT+1)'(1) : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q         <= RST_STATE;
            tag_q           <= '0;
            data_q          <= '0;
            hit_q           <= 1'b0;
            req_ready_q     <= RST_REQ_READY;
            cam_read_q      <= 1'b0;
            cam_check_tag_q <= '0;
            cam_write_n_q   <= IDLE_CAM_WRITE_N;
            cam_w_addr_q    <= '0;
            cam_wdata_q     <= '0;
            cam_new_tag_q   <= '0;
            cam_new_valid_q <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_tag_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_hit_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tag_q           <= tag_d;
            data_q          <= data_d;
            hit_q           <= hit_d;
            req_ready_q     <= req_ready_d;
            cam_read_q      <= cam_read_d;
            cam_check_tag_q <= cam_check_tag_d;
            cam_write_n_q   <= cam_write_n_d;
            cam_w_addr_q    <= cam_w_addr_d;
            cam_wdata_q     <= cam_wdata_d;
            cam_new_tag_q   <= cam_new_tag_d;
            cam_new_valid_q <= cam_new_valid_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_tag_q   <= mem_req_tag_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_hit_q       <= rsp_hit_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.cam_read      = cam_read_q;
    assign bus.cam_check_tag = cam_check_tag_q;
    assign bus.cam_write_    = cam_write_n_q;
    assign bus.cam_w_addr    = cam_w_addr_q;
    assign bus.cam_wdata     = cam_wdata_q;
    assign bus.cam_new_tag   = cam_new_tag_q;
    assign bus.cam_new_valid = cam_new_valid_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_tag   = mem_req_tag_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_hit       = rsp_hit_q;

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Directed bench for cam_fill_ctrl: vector table for a miss then a hit,
// plus hand sequences for backpressure, reset abort, wrap and flush.
module tb_cam_fill_ctrl;
    import cam_ctrl_pkg::*;

    typedef struct packed {
        logic       rdy;
        logic       rd;
        logic [7:0] ct;
        logic       mv;
        logic [7:0] mt;
        logic       wn;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [7:0] nt;
        logic       nv;
        logic       rv;
        logic [7:0] rdat;
        logic       rh;
    } out_t;

    typedef struct {
        logic       rv;
        logic [7:0] tag;
        logic       fl;
        logic       cf;
        logic [7:0] cd;
        logic       mrr;
        logic       mrv;
        logic [7:0] mrd;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cam_fill_ctrl_if #(.WORDS(8), .BITS(8), .TAG_SZ(8)) bus ();

    cam_fill_ctrl #(.WORDS(8), .BITS(8), .TAG_SZ(8)) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    function automatic out_t mo(input logic rdy, input logic rd, input logic [7:0] ct,
                                input logic mv, input logic [7:0] mt, input logic wn,
                                input logic [2:0] wa, input logic [7:0] wd, input logic [7:0] nt,
                                input logic nv, input logic rv, input logic [7:0] rdat,
                                input logic rh);
        out_t o;
        o = '{rdy, rd, ct, mv, mt, wn, wa, wd, nt, nv, rv, rdat, rh};
        return o;
    endfunction

    function automatic out_t obs();
        return mo(bus.req_ready, bus.cam_read, bus.cam_check_tag, bus.mem_req_valid,
                  bus.mem_req_tag, bus.cam_write_, bus.cam_w_addr, bus.cam_wdata,
                  bus.cam_new_tag, bus.cam_new_valid, bus.rsp_valid, bus.rsp_data, bus.rsp_hit);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] tag);
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        step();
        bus.req_valid = 1'b0;
        bus.req_tag   = 8'h00;
    endtask

    // Zero-wait memory model; starts with the controller in LOOKUP, ends back in IDLE.
    task automatic finish_miss(input logic [7:0] data, output logic [2:0] fa,
                               output logic [7:0] mt, output logic [7:0] rd,
                               output logic rh, output int lat, output int nwr);
        logic pend;
        fa = '0; mt = '0; rd = '0; rh = 1'b0; lat = 0; nwr = 0; pend = 1'b0;
        bus.cam_found     = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (!bus.cam_write_) begin
                fa = bus.cam_w_addr;
                nwr++;
            end
            if (bus.mem_req_valid) mt = bus.mem_req_tag;
            if (bus.rsp_valid) begin
                rd  = bus.rsp_data;
                rh  = bus.rsp_hit;
                lat = c;
                break;
            end
            bus.mem_rsp_valid = pend;
            bus.mem_rsp_data  = pend ? data : 8'h00;
            pend = bus.mem_req_valid;
            step();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 8'h00;
        bus.mem_req_ready = 1'b0;
        step();
    endtask

    out_t idle_o, busy_o;
    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fa;
        logic [7:0] mt, rd;
        logic       rh;
        int         lat, nwr;

        idle_o = mo(1, 0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        busy_o = mo(0, 0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // rv tag fl cf cd mrr mrv mrd : expected outputs after the next edge
        vecs[0] = '{1, 8'h12, 0, 0, 8'h00, 0, 0, 8'h00, mo(0, 1, 8'h12, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)};
        vecs[1] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, mo(0, 0, 8'h00, 1, 8'h12, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)};
        vecs[2] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, busy_o};
        vecs[3] = '{0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h5A, mo(0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h5A, 8'h12, 1, 0, 8'h00, 0)};
        vecs[4] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, mo(0, 0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 1, 8'h5A, 0)};
        vecs[5] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, idle_o};
        vecs[6] = '{1, 8'h12, 0, 0, 8'h00, 0, 0, 8'h00, mo(0, 1, 8'h12, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)};
        vecs[7] = '{0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h00, mo(0, 0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 1, 8'h5A, 1)};
        vecs[8] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, idle_o};

        bus.req_valid = 1'b0; bus.req_tag = 8'h00; bus.flush = 1'b0;
        bus.cam_found = 1'b0; bus.cam_data = 8'h00; bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 8'h00;

        repeat (3) step();
        chk("reset_outputs", 64'(obs()), 64'(idle_o));
        rst_ = 1'b1;
        step();

        // Miss on 0x12 followed by a hit on 0x12
        for (int i = 0; i < 9; i++) begin
            bus.req_valid = vecs[i].rv;  bus.req_tag = vecs[i].tag; bus.flush = vecs[i].fl;
            bus.cam_found = vecs[i].cf;  bus.cam_data = vecs[i].cd;
            bus.mem_req_ready = vecs[i].mrr; bus.mem_rsp_valid = vecs[i].mrv;
            bus.mem_rsp_data = vecs[i].mrd;
            step();
            chk($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
        end
        bus.cam_found = 1'b0; bus.cam_data = 8'h00;

        // Memory backpressure with a spurious response during MEM_REQ
        issue(8'h33);
        chk("bp_lookup", 64'(obs()), 64'(mo(0, 1, 8'h33, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)));
        step();
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("bp_hold%0d", j), 64'(obs()), 64'(mo(0, 0, 8'h00, 1, 8'h33, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)));
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 8'hEE;
            step();
        end
        chk("bp_hold3", 64'(obs()), 64'(mo(0, 0, 8'h00, 1, 8'h33, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)));
        bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 8'h00;
        step();
        chk("bp_wait", 64'(obs()), 64'(busy_o));
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 8'h77;
        step();
        chk("bp_fill", 64'(obs()), 64'(mo(0, 0, 8'h00, 0, 8'h00, 0, 3'd1, 8'h77, 8'h33, 1, 0, 8'h00, 0)));
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 8'h00;
        step();
        chk("bp_resp", 64'(obs()), 64'(mo(0, 0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 1, 8'h77, 0)));
        step();
        chk("bp_idle", 64'(obs()), 64'(idle_o));

        // Reset during MEM_WAIT aborts without a fill or response
        issue(8'h44);
        bus.mem_req_ready = 1'b1;
        step();
        step();
        bus.mem_req_ready = 1'b0;
        chk("rst_memwait", 64'(obs()), 64'(busy_o));
        rst_ = 1'b0;
        #1;
        chk("rst_async", 64'(obs()), 64'(idle_o));
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 8'h99;
        step();
        rst_ = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("rst_after%0d", j), 64'(obs()), 64'(idle_o));
        end
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 8'h00;

        // Nine misses wrap the victim pointer 0..7,0
        for (int i = 0; i < 9; i++) begin
            issue(8'h20 + 8'(i));
            finish_miss(8'hA0 + 8'(i), fa, mt, rd, rh, lat, nwr);
            chk($sformatf("wrap_miss%0d", i), 64'({fa, mt, rd, rh, 8'(lat), 8'(nwr)}),
                64'({3'(i % 8), 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b0, 8'd5, 8'd1}));
        end

        // Flush and request together: flush first, request accepted afterwards
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_tag = 8'h55;
        step();
        bus.flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("flush%0d", k), 64'(obs()), 64'(mo(0, 0, 8'h00, 0, 8'h00, 0, 3'(k), 8'h00, 8'h00, 0, 0, 8'h00, 0)));
            step();
        end
        chk("flush_idle", 64'(obs()), 64'(idle_o));
        step();
        bus.req_valid = 1'b0; bus.req_tag = 8'h00;
        chk("flush_accept", 64'(obs()), 64'(mo(0, 1, 8'h55, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 0)));
        finish_miss(8'hC5, fa, mt, rd, rh, lat, nwr);
        chk("flush_refill", 64'({fa, mt, rd, rh, 8'(lat), 8'(nwr)}),
            64'({3'd0, 8'h55, 8'hC5, 1'b0, 8'd5, 8'd1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_fill_ctrl.md
# cam_fill_ctrl

Request-side controller for the tag-matching CAM cache: it accepts tagged read requests, drives the CAM lookup, and returns the data on a hit. On a miss it fetches the word from backing memory, then installs it in the CAM with a write. It sits between the requesting client and the CAM plus backing memory, and owns replacement (round-robin) and flush.

## Interface
- WORDS, 8, CAM entries
- BITS, 8, data width
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, entry index MSB
- clk  in  1  system clock
- rst_  in  1  asynchronous, active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  controller can accept a request
- req_tag  in  TAG_SZ  requested tag
- rsp_valid  out  1  response valid, one-cycle pulse
- rsp_data  out  BITS  response data
- rsp_hit  out  1  1 = served from CAM, 0 = filled from memory
- flush  in  1  invalidate all CAM entries
- cam_read  out  1  CAM lookup enable
- cam_check_tag  out  TAG_SZ  lookup tag
- cam_data  in  BITS  CAM lookup data
- cam_found  in  1  CAM hit
- cam_write_  out  1  CAM write strobe, active-low
- cam_w_addr  out  ADDR_LEFT+1  CAM write index
- cam_wdata  out  BITS  CAM write data
- cam_new_tag  out  TAG_SZ  CAM write tag
- cam_new_valid  out  1  CAM valid bit to write
- mem_req_valid  out  1  memory fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_tag  out  TAG_SZ  tag to fetch
- mem_rsp_valid  in  1  memory data valid
- mem_rsp_data  in  BITS  fetched data

## Operation
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP, FLUSH.
- IDLE: req_ready=1. flush=1 → FLUSH; flush wins over a simultaneous req_valid. Otherwise req_valid=1 → latch req_tag → LOOKUP.
- LOOKUP: cam_read=1 and cam_check_tag=latched tag. Sample cam_found/cam_data at the end of the cycle. Hit → latch data, rsp_hit=1 → RESP. Miss → MEM_REQ.
- MEM_REQ: mem_req_valid=1 and mem_req_tag held until the cycle mem_req_ready=1 → MEM_WAIT.
- MEM_WAIT: wait for mem_rsp_valid=1 → latch mem_rsp_data → FILL. mem_rsp_valid in any other state is ignored.
- FILL: cam_write_=0 for exactly one cycle with w_addr=victim pointer, wdata=fetched data, new_tag=latched tag, new_valid=1. The victim pointer increments, wrapping from WORDS-1 to 0. Then → RESP with rsp_hit=0.
- RESP: rsp_valid=1 for one cycle with rsp_data and rsp_hit → IDLE. Clients must not backpressure the response.
- FLUSH: WORDS consecutive cycles of cam_write_=0, w_addr 0..WORDS-1, new_valid=0, wdata=0, new_tag=0. Victim pointer resets to 0. Then → IDLE.
- req_ready=0 in every state except IDLE. flush outside IDLE is ignored; the requester must hold it until IDLE.
- Idle values: cam_write_=1, cam_read=0, and all data/tag/address outputs are 0 when not active.

## Timing
- Reset (rst_=0, asynchronous): state IDLE, victim pointer 0, all latches 0. Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_hit=0, cam_read=0, cam_write_=1, mem_req_valid=0, and all buses 0.
- Reset mid-operation aborts the operation: no CAM write and no response. A pending memory handshake is dropped.
- Hit latency: request accepted at cycle N, rsp_valid at N+2.
- Miss latency: N+1 LOOKUP, then MEM_REQ for ≥1 cycle, then MEM_WAIT for ≥1 cycle, then FILL 1 cycle, then RESP 1 cycle. With zero-wait memory, rsp_valid is at N+5.
- The CAM write issued in FILL becomes visible to the LOOKUP of the next request. The earliest next acceptance is the cycle after RESP.
- Flush occupies WORDS+1 cycles from the accepting IDLE cycle back to IDLE.

## Structure
- Package cam_ctrl_pkg holds the state enum (state_t) and the reset/idle constants.
- One sub-module, cam_victim_ptr: a round-robin counter of ADDR_LEFT+1 bits with inc and clr inputs, asynchronous active-low reset, and wrap at WORDS-1.
- The CAM itself is not instantiated here; the two blocks connect at the top level.

## Test plan
- Reset, then request tag 0x12 with cam_found=0 and memory returning 0x5A → one mem request with tag 0x12; FILL writes addr 0, tag 0x12, data 0x5A, valid 1; rsp_data=0x5A, rsp_hit=0.
- Tag 0x12 again with cam_found=1 and cam_data=0x5A → no mem_req_valid; rsp_valid at N+2 with data 0x5A and rsp_hit=1.
- Nine consecutive misses (tags 0x20–0x28) → fill addresses 0,1,…,7,0, confirming the wrap.
- mem_req_ready held low for 3 cycles → mem_req_valid and mem_req_tag stay stable for 3 cycles; a spurious mem_rsp_valid during MEM_REQ is ignored.
- flush and req_valid together in IDLE → 8 cycles of cam_write_=0 with addr 0..7 and new_valid=0; the request is accepted afterwards; the next miss fills addr 0.
- rst_ pulsed low during MEM_WAIT → outputs return to reset values immediately; no FILL write and no rsp_valid.
